bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15: cycles the source drives the bus before the load strobe.
REQ-002 SHALL have parameters DELAY_RISE and DELAY_FALL, default 0: simulation delay applied to every output.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  system clock; all state changes on the rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 REQ  input  1  transfer request, sampled only in IDLE.
REQ-007 SRC_SEL  input  2  index of the source register that drives the main bus.
REQ-008 DST_SEL  input  2  index of the destination register that loads from the main bus.
REQ-009 ASSERT_MAIN_bar  output  4  per-register main-bus assert, active-low, one-cold.
REQ-010 LOAD  output  4  per-register latch enable, active-high, one-hot.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 DONE  output  1  one-cycle pulse marking a completed transfer.
REQ-013 ERR  output  1  one-cycle pulse marking a rejected request (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, STROBE, HOLD and FIN.
REQ-015 In IDLE with REQ=1, the block SHALL capture SRC_SEL/DST_SEL at that edge and enter SETTLE.
- Selects are ignored after capture until the block returns to IDLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with ASSERT_MAIN_bar[src]=0 and LOAD=0.
REQ-017 STROBE SHALL last 1 cycle, with ASSERT_MAIN_bar[src]=0 and LOAD[dst]=1.
REQ-018 HOLD SHALL last 1 cycle, with ASSERT_MAIN_bar[src]=0 and LOAD=0.
- This gives the destination latch hold time after LE falls.
REQ-019 FIN SHALL last 1 cycle, with DONE=1, BUSY=1 and all asserts/loads inactive, then return to IDLE.
REQ-020 Latency: with REQ accepted at edge 0, DONE SHALL be high in cycle SETTLE_CYCLES+3.
- Next REQ is accepted no earlier than edge SETTLE_CYCLES+4.
REQ-021 At most one ASSERT_MAIN_bar bit SHALL be low, and at most one LOAD bit high, in any cycle.
REQ-022 LOAD SHALL never be high unless the matching source assert has been low for at least SETTLE_CYCLES preceding cycles.
REQ-023 REQ while BUSY=1 SHALL be ignored (not queued).
REQ-024 In IDLE, outputs SHALL be: ASSERT_MAIN_bar=4'b1111, LOAD=4'b0000, BUSY=0, DONE=0, ERR=0.

Reset
REQ-025 RESET=1 at an edge SHALL force IDLE and the REQ-024 output values, from any state.
REQ-026 Reset mid-transfer SHALL abort without a DONE pulse; any LOAD high in that cycle drops after the edge.
REQ-027 RESET and REQ high together SHALL give reset precedence; the request is discarded.

Configuration
REQ-028 Macro BUS_XFER_SELF_CHECK_EN defined: a REQ with SRC_SEL==DST_SEL SHALL be rejected.
- Rejection: one-cycle ERR pulse in the next cycle, state stays IDLE, no bus activity.
REQ-029 Macro BUS_XFER_SELF_CHECK_EN undefined: ERR SHALL be tied 0, and SRC_SEL==DST_SEL SHALL run as a normal transfer.

Verification
REQ-030 SETTLE_CYCLES=1, REQ src=1 dst=2 at edge 0 -> ASSERT_MAIN_bar=4'b1101 in cycles 1-3; LOAD=4'b0100 in cycle 2 only; DONE=1 in cycle 4; BUSY=1 in cycles 1-4.
REQ-031 SETTLE_CYCLES=3, src=0 dst=3 -> ASSERT_MAIN_bar=4'b1110 in cycles 1-5; LOAD=4'b1000 in cycle 4 only; DONE in cycle 6.
REQ-032 REQ held high continuously, src=2 dst=0 -> transfers back-to-back with one IDLE cycle between FIN and the next SETTLE; REQ pulses during BUSY are dropped.
REQ-033 RESET asserted in the STROBE cycle -> next cycle ASSERT_MAIN_bar=4'b1111, LOAD=0, BUSY=0, no DONE.
REQ-034 With BUS_XFER_SELF_CHECK_EN, REQ src=dst=1 -> ERR=1 in cycle 1, BUSY=0, ASSERT_MAIN_bar=4'b1111 throughout; without the macro -> normal transfer and DONE in cycle 4.
REQ-035 Random transfers, all cycles -> REQ-021 and REQ-022 invariants hold.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_xfer_ctrl
// Purpose  : Register-to-register transfer sequencer for a shared main bus.
//            On an accepted REQ, the selected source drives the bus for
//            SETTLE_CYCLES cycles. The destination then gets a one-cycle
//            load strobe. The source keeps driving for one more hold cycle,
//            and a FIN cycle pulses DONE.
// Ports    : CLK             - system clock, rising edge
//            RESET           - synchronous, active-high reset
//            REQ             - transfer request, sampled only in IDLE
//            SRC_SEL[1:0]    - source register index (drives the bus)
//            DST_SEL[1:0]    - destination register index (loads from bus)
//            ASSERT_MAIN_bar - per-register bus assert, active-low, one-cold
//            LOAD            - per-register latch enable, one-hot
//            BUSY            - high in every state except IDLE
//            DONE            - one-cycle pulse, transfer completed
//            ERR             - one-cycle pulse, request rejected
// Config   : BUS_XFER_SELF_CHECK_EN - when defined, a request with
//            SRC_SEL==DST_SEL is rejected with an ERR pulse. When it is
//            undefined, ERR is tied low and such a request runs normally.
// Revision : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl #(
  parameter int SETTLE_CYCLES = 1,  // legal range 1..15
  parameter int DELAY_RISE    = 0,
  parameter int DELAY_FALL    = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ,
  input  logic [1:0] SRC_SEL,
  input  logic [1:0] DST_SEL,
  output logic [3:0] ASSERT_MAIN_bar,
  output logic [3:0] LOAD,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  // The settle counter runs from SETTLE_CYCLES-1 down to 0. The SETTLE
  // state therefore lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] c_CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_dst;
  logic [3:0] r_assert_n;
  logic [3:0] r_load;
  logic       r_busy;
  logic       r_done;

  // The output delays exist only for timing annotation in simulation.
  // The synthesizable implementation has zero delay.
  logic w_unused_delays;
  assign w_unused_delays = |{DELAY_RISE, DELAY_FALL};

`ifdef BUS_XFER_SELF_CHECK_EN
  logic r_err;
  logic w_same_sel;
  assign w_same_sel = (SRC_SEL == DST_SEL);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_dst      <= 2'd0;
      r_assert_n <= 4'b1111;
      r_load     <= 4'b0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef BUS_XFER_SELF_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
`ifdef BUS_XFER_SELF_CHECK_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (REQ) begin
`ifdef BUS_XFER_SELF_CHECK_EN
            if (w_same_sel) begin
              // Rejected: stay idle with the bus quiet, and flag it for one cycle.
              r_err <= 1'b1;
            end else begin
`else
            begin
`endif
              // Outputs are registered, so the source assert is loaded here.
              // It is then already low in the first SETTLE cycle.
              r_state    <= ST_SETTLE;
              r_cnt      <= c_CNT_INIT;
              r_dst      <= DST_SEL;
              r_assert_n <= ~(4'b0001 << SRC_SEL);
              r_busy     <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_STROBE;
            r_load  <= 4'b0001 << r_dst;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          // LOAD falls while the source keeps driving. This gives the
          // destination latch its hold time.
          r_state <= ST_HOLD;
          r_load  <= 4'b0000;
        end
        ST_HOLD: begin
          r_state    <= ST_FIN;
          r_assert_n <= 4'b1111;
          r_done     <= 1'b1;
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_assert_n <= 4'b1111;
          r_load     <= 4'b0000;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign ASSERT_MAIN_bar = r_assert_n;
  assign LOAD            = r_load;
  assign BUSY            = r_busy;
  assign DONE            = r_done;
`ifdef BUS_XFER_SELF_CHECK_EN
  assign ERR             = r_err;
`else
  assign ERR             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bus_xfer_ctrl
// Purpose  : Self-checking bench for bus_xfer_ctrl. Two instances are used,
//            with SETTLE_CYCLES=1 and SETTLE_CYCLES=3. Each instance is
//            checked every cycle against a phase-count reference model.
//            Directed sequences also carry hand-computed expectations, and
//            randomized traffic follows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_xfer_ctrl;

`ifdef BUS_XFER_SELF_CHECK_EN
  localparam bit c_CHK = 1'b1;
`else
  localparam bit c_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       req [2];
  logic [1:0] src [2];
  logic [1:0] dst [2];

  logic [3:0] am0, ld0, am1, ld1;
  logic       busy0, done0, err0, busy1, done1, err1;

  bus_xfer_ctrl #(.SETTLE_CYCLES(1), .DELAY_RISE(0), .DELAY_FALL(0)) u_dut0 (
    .CLK(clk), .RESET(rst[0]), .REQ(req[0]), .SRC_SEL(src[0]), .DST_SEL(dst[0]),
    .ASSERT_MAIN_bar(am0), .LOAD(ld0), .BUSY(busy0), .DONE(done0), .ERR(err0)
  );

  bus_xfer_ctrl #(.SETTLE_CYCLES(3), .DELAY_RISE(0), .DELAY_FALL(0)) u_dut1 (
    .CLK(clk), .RESET(rst[1]), .REQ(req[1]), .SRC_SEL(src[1]), .DST_SEL(dst[1]),
    .ASSERT_MAIN_bar(am1), .LOAD(ld1), .BUSY(busy1), .DONE(done1), .ERR(err1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model. A transfer is a phase number p: 0 is idle, and 1..S+3
  // counts cycles since acceptance. Outputs are simple functions of p.
  // ---------------------------------------------------------------------
  int         m_p   [2];
  logic [1:0] m_src [2];
  logic [1:0] m_dst [2];
  logic       m_err [2];
  int         run   [2][4];   // consecutive preceding cycles each assert was low
  bit         cmp_en = 1'b0;

  function automatic int s_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [3:0] exp_am(input int d);
    logic [3:0] one;
    one = 4'b0001;
    if (m_p[d] >= 1 && m_p[d] <= s_of(d) + 2) return ~(one << m_src[d]);
    return 4'b1111;
  endfunction

  function automatic logic [3:0] exp_ld(input int d);
    logic [3:0] one;
    one = 4'b0001;
    if (m_p[d] == s_of(d) + 1) return one << m_dst[d];
    return 4'b0000;
  endfunction

  task automatic model_step(input int d);
    if (rst[d]) begin
      m_p[d]   = 0;
      m_err[d] = 1'b0;
    end else if (m_p[d] == 0) begin
      m_err[d] = 1'b0;
      if (req[d]) begin
        if (c_CHK && (src[d] == dst[d])) begin
          m_err[d] = 1'b1;
        end else begin
          m_p[d]   = 1;
          m_src[d] = src[d];
          m_dst[d] = dst[d];
        end
      end
    end else begin
      m_err[d] = 1'b0;
      m_p[d]   = (m_p[d] == s_of(d) + 3) ? 0 : m_p[d] + 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp(input int d, input logic [3:0] a, input logic [3:0] l,
                     input logic b, input logic dn, input logic e);
    string p;
    p = $sformatf("s%0d_", s_of(d));
    chk4({p, "assert"}, a, exp_am(d));
    chk4({p, "load"}, l, exp_ld(d));
    chk1({p, "busy"}, b, (m_p[d] != 0));
    chk1({p, "done"}, dn, (m_p[d] == s_of(d) + 3));
    chk1({p, "err"}, e, m_err[d]);
    chk1({p, "one_cold"}, ($countones(~a) <= 1), 1'b1);
    chk1({p, "one_hot"}, ($countones(l) <= 1), 1'b1);
    if (l != 4'b0000) begin
      chk1({p, "load_without_src"}, (a != 4'b1111), 1'b1);
      for (int i = 0; i < 4; i++)
        if (a[i] == 1'b0) chk1({p, "settle_before_load"}, (run[d][i] >= s_of(d)), 1'b1);
    end
    for (int i = 0; i < 4; i++)
      run[d][i] = (a[i] == 1'b0) ? run[d][i] + 1 : 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, am0, ld0, busy0, done0, err0);
      cmp(1, am1, ld1, busy1, done1, err1);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int nd;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; src[d] = 2'd0; dst[d] = 2'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk4("reset_assert", am0, 4'b1111);
    chk4("reset_load", ld0, 4'b0000);
    chk1("reset_busy", busy0, 1'b0);
    chk1("reset_done", done1, 1'b0);
    chk1("reset_err", err1, 1'b0);

    // S=1 src1->dst2, and S=3 src0->dst3, both accepted at edge 0
    req[0] = 1'b1; src[0] = 2'd1; dst[0] = 2'd2;
    req[1] = 1'b1; src[1] = 2'd0; dst[1] = 2'd3;
    @(posedge clk);
    #1;
    req[0] = 1'b0; req[1] = 1'b0;
    src[0] = 2'd3; dst[0] = 2'd0;   // changes after capture have no effect
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk4("lit_s1_assert", am0, (k >= 1 && k <= 3) ? 4'b1101 : 4'b1111);
      chk4("lit_s1_load", ld0, (k == 2) ? 4'b0100 : 4'b0000);
      chk1("lit_s1_done", done0, (k == 4));
      chk1("lit_s1_busy", busy0, (k >= 1 && k <= 4));
      chk4("lit_s3_assert", am1, (k >= 1 && k <= 5) ? 4'b1110 : 4'b1111);
      chk4("lit_s3_load", ld1, (k == 4) ? 4'b1000 : 4'b0000);
      chk1("lit_s3_done", done1, (k == 6));
    end

    // Reset asserted during the STROBE cycle aborts without DONE
    req[0] = 1'b1; src[0] = 2'd3; dst[0] = 2'd0;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);                 // cycle 1: SETTLE
    @(negedge clk);                 // cycle 2: STROBE
    chk4("lit_strobe_load", ld0, 4'b0001);
    rst[0] = 1'b1;
    @(negedge clk);
    chk4("lit_abort_assert", am0, 4'b1111);
    chk4("lit_abort_load", ld0, 4'b0000);
    chk1("lit_abort_busy", busy0, 1'b0);
    chk1("lit_abort_done", done0, 1'b0);
    rst[0] = 1'b0;
    @(negedge clk);
    chk1("lit_abort_done_after", done0, 1'b0);

    // Reset and REQ together: the request is discarded
    rst[0] = 1'b1; req[0] = 1'b1; src[0] = 2'd0; dst[0] = 2'd1;
    @(negedge clk);
    rst[0] = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk1("lit_rst_prec_busy", busy0, 1'b0);
    chk4("lit_rst_prec_assert", am0, 4'b1111);

    // Same source and destination
    req[0] = 1'b1; src[0] = 2'd1; dst[0] = 2'd1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
`ifdef BUS_XFER_SELF_CHECK_EN
      chk1("lit_same_err", err0, (k == 1));
      chk1("lit_same_busy", busy0, 1'b0);
      chk4("lit_same_assert", am0, 4'b1111);
`else
      chk1("lit_same_err", err0, 1'b0);
      chk1("lit_same_done", done0, (k == 4));
      chk4("lit_same_assert", am0, (k >= 1 && k <= 3) ? 4'b1101 : 4'b1111);
`endif
    end

    // REQ held high: back-to-back transfers with one IDLE cycle between them
    req[0] = 1'b1; src[0] = 2'd2; dst[0] = 2'd0;
    nd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done0) nd++;
      if (k == 5) chk1("lit_b2b_idle_gap", busy0, 1'b0);
      if (k == 6) chk4("lit_b2b_second_settle", am0, 4'b1011);
    end
    chki("lit_b2b_done_count", nd, 4);
    req[0] = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 63) == 0);
        req[d] = ($urandom_range(0, 2) != 0);
        src[d] = 2'($urandom_range(0, 3));
        dst[d] = 2'($urandom_range(0, 3));
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req[d] = 1'b0;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
